// File: rtl/multicycle_control_unit.sv
// Multi-cycle J17 control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB with sticky HALT and FAULT states.
module multicycle_control_unit #(
   parameter int INSTR_W     = 32,
   parameter int OPC_W       = 6,
   parameter int REG_W       = 5,
   parameter int IMM_W       = 20,
   parameter int ALU_W       = 6,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   input  logic               mem_ready,
   input  logic               flag_zero,
   input  logic               flag_neg,
   output logic               im_req,
   output logic [REG_W-1:0]   op1,
   output logic               flag,
   output logic [IMM_W-1:0]   op2,
   output logic [ALU_W-1:0]   alucode,
   output logic               im_control,
   output logic               reg_enable,
   output logic               ram_enable,
   output logic [2:0]         pc_control,
   output logic               halted,
   output logic               fault,
   output logic [2:0]         state
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_MULI = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_DIVI = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(9);
   localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(10);
   localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(11);
   localparam logic [OPC_W-1:0] OP_MOD  = OPC_W'(12);
   localparam logic [OPC_W-1:0] OP_SL   = OPC_W'(13);
   localparam logic [OPC_W-1:0] OP_SR   = OPC_W'(14);
   localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(15);
   localparam logic [OPC_W-1:0] OP_JE   = OPC_W'(16);
   localparam logic [OPC_W-1:0] OP_JB   = OPC_W'(17);
   localparam logic [OPC_W-1:0] OP_JA   = OPC_W'(18);
   localparam logic [OPC_W-1:0] OP_JNE  = OPC_W'(19);
   localparam logic [OPC_W-1:0] OP_JBE  = OPC_W'(20);
   localparam logic [OPC_W-1:0] OP_JAE  = OPC_W'(21);
   localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(22);
   localparam logic [OPC_W-1:0] OP_JNZ  = OPC_W'(23);
   localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(24);
   localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(25);
   localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(26);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
   } state_e;

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;

   logic [OPC_W-1:0] opc;
   logic [ALU_W-1:0] alu_sel;
   logic             imm_sel;
   logic             is_jump;
   logic             taken;
   logic             mov_mem;

   assign opc     = ir_q[INSTR_W-1 -: OPC_W];
   assign op1     = ir_q[IMM_W+REG_W : IMM_W+1];
   assign flag    = ir_q[IMM_W];
   assign op2     = ir_q[IMM_W-1:0];
   assign state   = state_q;
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign is_jump = (opc >= OP_JMP) && (opc <= OP_JNZ);
   assign mov_mem = (opc == OP_MOV) && ir_q[IMM_W];

   always_comb begin
      alu_sel = '0;
      imm_sel = 1'b0;
      taken   = 1'b0;
      case (opc)
         OP_ADD, OP_ADDI: alu_sel = ALU_W'(1);
         OP_SUB, OP_SUBI: alu_sel = ALU_W'(2);
         OP_MUL, OP_MULI: alu_sel = ALU_W'(3);
         OP_DIV, OP_DIVI: alu_sel = ALU_W'(4);
         OP_NOT:          alu_sel = ALU_W'(5);
         OP_AND:          alu_sel = ALU_W'(6);
         OP_OR:           alu_sel = ALU_W'(7);
         OP_XOR:          alu_sel = ALU_W'(8);
         OP_MOD:          alu_sel = ALU_W'(9);
         OP_SL:           alu_sel = ALU_W'(10);
         OP_SR:           alu_sel = ALU_W'(11);
         OP_MOV:          alu_sel = ALU_W'(12);
         default:         alu_sel = '0;
      endcase
      imm_sel = ((opc >= OP_ADDI) && (opc <= OP_DIVI)) ||
                ((opc == OP_MOV) && !ir_q[IMM_W]);
      case (opc)
         OP_JMP:         taken = 1'b1;
         OP_JE, OP_JZ:   taken = flag_zero;
         OP_JNE, OP_JNZ: taken = !flag_zero;
         OP_JB:          taken = flag_neg;
         OP_JA:          taken = !flag_neg && !flag_zero;
         OP_JBE:         taken = flag_neg || flag_zero;
         OP_JAE:         taken = !flag_neg;
         default:        taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      cnt_d      = cnt_q;
      im_req     = 1'b0;
      alucode    = '0;
      im_control = 1'b0;
      reg_enable = 1'b0;
      ram_enable = 1'b0;
      pc_control = 3'd0;
      halted     = 1'b0;
      fault      = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            im_req = 1'b1;
            if (instr_valid) begin
               ir_d    = instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (1'b1)
               (opc > OP_HLT): state_d = S_FAULT;
               (opc == OP_NOP): begin
                  pc_control = 3'd1;
                  state_d    = S_FETCH;
               end
               (opc == OP_HLT): state_d = S_HALT;
               default:         state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            if (is_jump) begin
               pc_control = taken ? 3'd2 : 3'd1;
               state_d    = S_FETCH;
            end else begin
               alucode    = alu_sel;
               im_control = imm_sel;
               state_d    = mov_mem ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            ram_enable = 1'b1;
            alucode    = ALU_W'(12);
            // a late mem_ready on the timeout cycle still completes
            if (mem_ready) begin
               cnt_d   = '0;
               state_d = S_WB;
            end else if (cnt_inc == CNT_MAX) begin
               cnt_d   = '0;
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WB: begin
            reg_enable = 1'b1;
            pc_control = 3'd1;
            alucode    = alu_sel;
            im_control = imm_sel;
            state_d    = S_FETCH;
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed and random instruction
// streams checked cycle by cycle against a trace-level reference model.
module tb_multicycle_control_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        mem_ready = 1'b0;
   logic        flag_zero = 1'b0;
   logic        flag_neg = 1'b0;
   logic        im_req;
   logic [4:0]  op1;
   logic        flag;
   logic [19:0] op2;
   logic [5:0]  alucode;
   logic        im_control;
   logic        reg_enable;
   logic        ram_enable;
   logic [2:0]  pc_control;
   logic        halted;
   logic        fault;
   logic [2:0]  state;

   multicycle_control_unit dut (
      .clock(clock), .reset_n(reset_n), .instr(instr),
      .instr_valid(instr_valid), .mem_ready(mem_ready),
      .flag_zero(flag_zero), .flag_neg(flag_neg), .im_req(im_req),
      .op1(op1), .flag(flag), .op2(op2), .alucode(alucode),
      .im_control(im_control), .reg_enable(reg_enable),
      .ram_enable(ram_enable), .pc_control(pc_control),
      .halted(halted), .fault(fault), .state(state)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_ir = '0;
   bit          m_z = 1'b0;
   bit          m_n = 1'b0;

   // alucode per opcode 0..26
   int alu_tab [27] = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0};

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit jump_taken(int opc);
      case (opc)
         15:      return 1'b1;
         16, 22:  return m_z;
         19, 23:  return !m_z;
         17:      return m_n;
         18:      return !m_n && !m_z;
         20:      return m_n || m_z;
         21:      return !m_n;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_all(string tag, int st);
      int   opc;
      bit   fl;
      int   e_pc, e_alu;
      bit   e_imm, e_reg, e_ram, e_req, e_halt, e_fault;
      opc = int'(m_ir[31:26]);
      fl = m_ir[20];
      e_pc = 0; e_alu = 0;
      e_imm = 0; e_reg = 0; e_ram = 0;
      e_req = 0; e_halt = 0; e_fault = 0;
      case (st)
         1: e_req = 1;
         2: if (opc == 25) e_pc = 1;
         3: begin
            if (opc >= 15 && opc <= 23) begin
               e_pc = jump_taken(opc) ? 2 : 1;
            end else begin
               e_alu = (opc < 27) ? alu_tab[opc] : 0;
               e_imm = (opc >= 4 && opc <= 7) || (opc == 24 && !fl);
            end
         end
         4: begin e_ram = 1; e_alu = 12; end
         5: begin
            e_reg = 1; e_pc = 1;
            e_alu = (opc < 27) ? alu_tab[opc] : 0;
            e_imm = (opc >= 4 && opc <= 7) || (opc == 24 && !fl);
         end
         6: e_halt = 1;
         7: e_fault = 1;
         default: ;
      endcase
      chk({tag, "/state"}, 32'(state), 32'(st));
      chk({tag, "/im_req"}, 32'(im_req), 32'(e_req));
      chk({tag, "/op1"}, 32'(op1), 32'(m_ir[25:21]));
      chk({tag, "/flag"}, 32'(flag), 32'(m_ir[20]));
      chk({tag, "/op2"}, 32'(op2), 32'(m_ir[19:0]));
      chk({tag, "/alucode"}, 32'(alucode), 32'(e_alu));
      chk({tag, "/im_control"}, 32'(im_control), 32'(e_imm));
      chk({tag, "/reg_enable"}, 32'(reg_enable), 32'(e_reg));
      chk({tag, "/ram_enable"}, 32'(ram_enable), 32'(e_ram));
      chk({tag, "/pc_control"}, 32'(pc_control), 32'(e_pc));
      chk({tag, "/halted"}, 32'(halted), 32'(e_halt));
      chk({tag, "/fault"}, 32'(fault), 32'(e_fault));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // asserts reset mid-cycle, checks outputs clear at once, restarts
   task automatic do_reset(string tag);
      #2;
      reset_n = 1'b0;
      instr_valid = 1'b1;
      instr = $urandom;
      #1;
      m_ir = '0;
      check_all({tag, "/in_reset"}, 0);
      @(negedge clock);
      check_all({tag, "/reset_held"}, 0);
      reset_n = 1'b1;
      step();
      check_all({tag, "/restart"}, 1);
   endtask

   // sticky-state hold with random inputs
   task automatic hold(string tag, int st, int n);
      for (int i = 0; i < n; i++) begin
         instr = $urandom;
         instr_valid = 1'($urandom);
         mem_ready = 1'($urandom);
         step();
         check_all(tag, st);
      end
   endtask

   // runs one instruction from FETCH; wait_c >= 15 means mem_ready never
   task automatic run_instr(string tag, int opc, int r, bit fl, int imm,
                            int wait_c, int fdly, bit z, bit n,
                            int abort_mem);
      logic [31:0] w;
      int q[$];
      int cur, fcount, mcount, mobs;
      w = {opc[5:0], r[4:0], fl, imm[19:0]};
      for (int i = 0; i < fdly; i++) q.push_back(1);
      q.push_back(2);
      if (opc > 26) q.push_back(7);
      else if (opc == 26) q.push_back(6);
      else if (opc == 25) q.push_back(1);
      else if (opc >= 15 && opc <= 23) begin
         q.push_back(3); q.push_back(1);
      end else if (opc == 24 && fl) begin
         q.push_back(3);
         if (wait_c >= 15) begin
            for (int i = 0; i < 15; i++) q.push_back(4);
            q.push_back(7);
         end else begin
            for (int i = 0; i <= wait_c; i++) q.push_back(4);
            q.push_back(5); q.push_back(1);
         end
      end else begin
         q.push_back(3); q.push_back(5); q.push_back(1);
      end
      m_z = z; m_n = n;
      flag_zero = z; flag_neg = n;
      cur = 1; fcount = 0; mcount = 0; mobs = 0;
      foreach (q[i]) begin
         mem_ready = 1'b0;
         if (cur == 1) begin
            instr_valid = (fcount == fdly);
            instr = instr_valid ? w : $urandom;
            fcount++;
         end else begin
            instr = $urandom;
            instr_valid = 1'($urandom);
         end
         if (cur == 4) begin
            mcount++;
            mem_ready = (mcount == wait_c + 1);
         end
         step();
         if (cur == 1 && q[i] == 2) m_ir = w;
         check_all(tag, q[i]);
         cur = q[i];
         if (cur == 4) begin
            mobs++;
            if (mobs == abort_mem) return;
         end
      end
   endtask

   initial begin
      do_reset("por");

      run_instr("add_r3", 0, 3, 0, $urandom, 0, 0, 0, 0, 0);
      run_instr("addi_5", 4, 7, 0, 5, 0, 0, 0, 0, 0);
      run_instr("ja_taken", 18, 1, 0, 20'h00100, 0, 0, 0, 0, 0);
      run_instr("ja_zero", 18, 1, 0, 20'h00200, 0, 1, 1, 0, 0);
      run_instr("jbe_neg", 20, 2, 0, 20'h00300, 0, 0, 0, 1, 0);
      run_instr("mov_wait3", 24, 9, 1, $urandom, 3, 0, 0, 0, 0);
      run_instr("mov_wait14", 24, 4, 1, $urandom, 14, 0, 0, 0, 0);
      run_instr("mov_reg", 24, 5, 0, $urandom, 0, 0, 0, 0, 0);
      run_instr("nop", 25, 0, 0, $urandom, 0, 2, 0, 0, 0);

      for (int k = 0; k < 40; k++) begin
         run_instr("rand", $urandom_range(0, 25), $urandom_range(0, 31),
                   1'($urandom), $urandom, $urandom_range(0, 14),
                   $urandom_range(0, 2), 1'($urandom), 1'($urandom), 0);
      end

      run_instr("mov_tmo", 24, 6, 1, $urandom, 1000, 0, 0, 0, 0);
      hold("tmo_sticky", 7, 20);
      do_reset("after_tmo");

      run_instr("illegal30", 30, 1, 0, $urandom, 0, 0, 0, 0, 0);
      hold("illegal_sticky", 7, 20);
      do_reset("after_illegal");

      run_instr("hlt", 26, 2, 1, $urandom, 0, 1, 0, 0, 0);
      hold("hlt_sticky", 6, 20);
      do_reset("after_hlt");

      run_instr("mov_abort", 24, 8, 1, $urandom, 1000, 0, 0, 0, 3);
      do_reset("mid_mem");
      run_instr("post_add", 1, 12, 0, $urandom, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
